// File: rtl/posit_op_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : posit_op_mailbox
// Brief    : Toggle-handshake mailbox between HPS PIO and a posit unit, with
//            per-operation timeout, sticky error flags and a completion count.
// Revision : 1.0 - initial release
// ============================================================================
module posit_op_mailbox #(
  parameter int WIDTH       = 32,
  parameter int OP_W        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_req_tog,
  input  logic             ctrl_clr_tog,
  input  logic [OP_W-1:0]  ctrl_op,
  input  logic [WIDTH-1:0] ctrl_num1,
  input  logic [WIDTH-1:0] ctrl_num2,
  output logic             status_ack_tog,
  output logic [WIDTH-1:0] status_result,
  output logic             status_busy,
  output logic             status_timeout,
  output logic             status_overrun,
  output logic [15:0]      status_count,
  output logic             unit_in_valid,
  input  logic             unit_in_ready,
  output logic [OP_W-1:0]  unit_op,
  output logic [WIDTH-1:0] unit_num1,
  output logic [WIDTH-1:0] unit_num2,
  input  logic             unit_out_valid,
  input  logic [WIDTH-1:0] unit_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [15:0]      c_timer_last = 16'(TIMEOUT_CYC - 1);
  localparam logic [WIDTH-1:0] c_nar        = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_q;
  logic             r_clr_q;
  logic [15:0]      r_timer;
  logic             r_ack_tog;
  logic [WIDTH-1:0] r_result;
  logic             r_timeout;
  logic             r_overrun;
  logic [15:0]      r_count;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_num1;
  logic [WIDTH-1:0] r_num2;

  logic w_req_edge;
  logic w_clr_edge;
  logic w_timer_hit;
  logic w_capture;
  logic w_done;
  logic w_expire;
  logic w_overrun_set;

  assign w_req_edge  = (r_req_q != ctrl_req_tog);
  assign w_clr_edge  = (r_clr_q != ctrl_clr_tog);
  assign w_timer_hit = (r_timer == c_timer_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_done        = 1'b0;
    w_expire      = 1'b0;
    w_overrun_set = 1'b0;
    unit_in_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        unit_in_valid = 1'b1;
        w_overrun_set = w_req_edge;
        // An acceptance on the last permitted cycle still counts as a timeout:
        // only a returned result can complete the operation.
        if (w_timer_hit) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (unit_in_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_overrun_set = w_req_edge;
        if (unit_out_valid) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timer_hit) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req_q   <= 1'b0;
      r_clr_q   <= 1'b0;
      r_timer   <= 16'd0;
      r_ack_tog <= 1'b0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= 16'd0;
      r_op      <= '0;
      r_num1    <= '0;
      r_num2    <= '0;
    end else begin
      r_req_q <= ctrl_req_tog;
      r_clr_q <= ctrl_clr_tog;

      if (w_capture) begin
        r_op    <= ctrl_op;
        r_num1  <= ctrl_num1;
        r_num2  <= ctrl_num2;
        r_timer <= 16'd0;
      end else if (r_state != ST_IDLE) begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_done) begin
        r_result  <= unit_result;
        r_ack_tog <= ~r_ack_tog;
        r_count   <= r_count + 16'd1;
      end else if (w_expire) begin
        r_result  <= c_nar;
        r_ack_tog <= ~r_ack_tog;
      end

      // Setting a flag takes precedence over a simultaneous clear.
      if (w_expire) begin
        r_timeout <= 1'b1;
      end else if (w_clr_edge) begin
        r_timeout <= 1'b0;
      end

      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (w_clr_edge) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign status_ack_tog = r_ack_tog;
  assign status_result  = r_result;
  assign status_busy    = (r_state != ST_IDLE);
  assign status_timeout = r_timeout;
  assign status_overrun = r_overrun;
  assign status_count   = r_count;
  assign unit_op        = r_op;
  assign unit_num1      = r_num1;
  assign unit_num2      = r_num2;

endmodule
`default_nettype wire

// File: tb/tb_posit_op_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_op_mailbox
// Brief    : Randomized self-checking bench; the bench plays the posit unit and
//            predicts each outcome from ready/response delays versus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_op_mailbox;

  localparam int WIDTH = 32;
  localparam int OP_W  = 2;
  localparam int T     = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             ctrl_req_tog;
  logic             ctrl_clr_tog;
  logic [OP_W-1:0]  ctrl_op;
  logic [WIDTH-1:0] ctrl_num1;
  logic [WIDTH-1:0] ctrl_num2;
  logic             status_ack_tog;
  logic [WIDTH-1:0] status_result;
  logic             status_busy;
  logic             status_timeout;
  logic             status_overrun;
  logic [15:0]      status_count;
  logic             unit_in_valid;
  logic             unit_in_ready;
  logic [OP_W-1:0]  unit_op;
  logic [WIDTH-1:0] unit_num1;
  logic [WIDTH-1:0] unit_num2;
  logic             unit_out_valid;
  logic [WIDTH-1:0] unit_result;

  posit_op_mailbox #(.WIDTH(WIDTH), .OP_W(OP_W), .TIMEOUT_CYC(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .ctrl_req_tog(ctrl_req_tog), .ctrl_clr_tog(ctrl_clr_tog),
    .ctrl_op(ctrl_op), .ctrl_num1(ctrl_num1), .ctrl_num2(ctrl_num2),
    .status_ack_tog(status_ack_tog), .status_result(status_result),
    .status_busy(status_busy), .status_timeout(status_timeout),
    .status_overrun(status_overrun), .status_count(status_count),
    .unit_in_valid(unit_in_valid), .unit_in_ready(unit_in_ready),
    .unit_op(unit_op), .unit_num1(unit_num1), .unit_num2(unit_num2),
    .unit_out_valid(unit_out_valid), .unit_result(unit_result)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic             exp_ack = 1'b0;
  logic [15:0]      exp_cnt = 16'd0;
  logic [WIDTH-1:0] exp_res = '0;
  logic             exp_to  = 1'b0;
  logic             exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 64'(status_busy), 64'd0);
    check({tag, "_ack"}, 64'(status_ack_tog), 64'(exp_ack));
    check({tag, "_res"}, 64'(status_result), 64'(exp_res));
    check({tag, "_cnt"}, 64'(status_count), 64'(exp_cnt));
    check({tag, "_to"}, 64'(status_timeout), 64'(exp_to));
    check({tag, "_ovr"}, 64'(status_overrun), 64'(exp_ovr));
    check({tag, "_ivld"}, 64'(unit_in_valid), 64'd0);
  endtask

  // d_r: cycles before the unit accepts; d_v: WAIT cycles before it answers.
  // ovr_k / clr_k: busy cycle (1-based) with an extra request / clear edge, 0 = none.
  task automatic run_op(input string tag, input logic [OP_W-1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res, input int d_r, input int d_v,
                        input int ovr_k, input int clr_k);
    int  last_k;
    bit  expire;
    if (d_r + 1 >= T) begin
      last_k = T; expire = 1'b1;
    end else if (d_r + d_v + 2 <= T) begin
      last_k = d_r + d_v + 2; expire = 1'b0;
    end else begin
      last_k = T; expire = 1'b1;
    end

    @(negedge clock);
    ctrl_op      = op;
    ctrl_num1    = a;
    ctrl_num2    = b;
    ctrl_req_tog = ~ctrl_req_tog;

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clock);
      ctrl_op        = OP_W'($urandom);
      ctrl_num1      = $urandom;
      ctrl_num2      = $urandom;
      unit_in_ready  = (k == d_r + 1);
      unit_out_valid = (k == d_r + d_v + 2) || (k <= d_r + 1 && $urandom_range(0, 1) == 1);
      unit_result    = (k == d_r + d_v + 2) ? res : WIDTH'($urandom);
      if (k == ovr_k) ctrl_req_tog = ~ctrl_req_tog;
      if (k == clr_k) ctrl_clr_tog = ~ctrl_clr_tog;
      if (k == clr_k) begin exp_to = 1'b0; exp_ovr = 1'b0; end
      if (k == ovr_k) exp_ovr = 1'b1;
      if (k == 1) begin
        check({tag, "_issue_vld"}, 64'(unit_in_valid), 64'd1);
        check({tag, "_op"}, 64'(unit_op), 64'(op));
        check({tag, "_num1"}, 64'(unit_num1), 64'(a));
        check({tag, "_num2"}, 64'(unit_num2), 64'(b));
      end
      if (k == last_k) begin
        check({tag, "_busy_pre"}, 64'(status_busy), 64'd1);
        check({tag, "_ack_pre"}, 64'(status_ack_tog), 64'(exp_ack));
        check({tag, "_num1_hold"}, 64'(unit_num1), 64'(a));
      end
    end

    exp_ack = ~exp_ack;
    if (expire) begin
      exp_res = {1'b1, {(WIDTH-1){1'b0}}};
      exp_to  = 1'b1;
    end else begin
      exp_res = res;
      exp_cnt = exp_cnt + 16'd1;
    end

    @(negedge clock);
    unit_in_ready  = 1'b0;
    unit_out_valid = 1'b0;
    check_status(tag);
  endtask

  task automatic clear_flags(input string tag);
    @(negedge clock);
    ctrl_clr_tog = ~ctrl_clr_tog;
    exp_to  = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clock);
    check({tag, "_to"}, 64'(status_timeout), 64'd0);
    check({tag, "_ovr"}, 64'(status_overrun), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    ctrl_req_tog   = 1'b0;
    ctrl_clr_tog   = 1'b0;
    ctrl_op        = '0;
    ctrl_num1      = '0;
    ctrl_num2      = '0;
    unit_in_ready  = 1'b0;
    unit_out_valid = 1'b0;
    unit_result    = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_status("reset");
    check("reset_num1", 64'(unit_num1), 64'd0);

    // Minimum-latency operation: 1.0 * 1.0 style operand pattern
    run_op("basic", 2'd0, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 0, 0, 0, 0);
    // Unit never accepts
    run_op("to_issue", 2'd1, 32'h1234_5678, 32'h0bad_cafe, 32'h0, T + 5, 0, 0, 0);
    clear_flags("clr1");
    // Acceptance on the very last cycle is still a timeout
    run_op("to_issue_edge", 2'd2, 32'h5, 32'h6, 32'h7, T - 1, 0, 0, 0);
    // Result on the exact timeout cycle wins
    clear_flags("clr2");
    run_op("exact_to", 2'd3, 32'hA5A5_0000, 32'h0000_5A5A, 32'h3C00_0001, 2, T - 4, 0, 0);
    // One cycle too late in WAIT
    run_op("to_wait", 2'd1, 32'h1, 32'h2, 32'h3, 2, T - 3, 0, 0);
    clear_flags("clr3");
    // Extra request while waiting, then clear; then set and clear together
    run_op("overrun", 2'd0, 32'h7000_0000, 32'h0100_0000, 32'h7100_0000, 0, 3, 3, 0);
    clear_flags("clr4");
    run_op("ovr_clr_same", 2'd2, 32'h11, 32'h22, 32'h33, 1, 2, 2, 2);

    for (int n = 0; n < 40; n++) begin
      int dr, dv, ok, ck;
      dr = $urandom_range(0, 4) == 0 ? $urandom_range(0, T + 2) : $urandom_range(0, 4);
      dv = $urandom_range(0, 3) == 0 ? $urandom_range(0, T) : $urandom_range(0, 4);
      ok = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      ck = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      run_op("rand", OP_W'($urandom), $urandom, $urandom, $urandom, dr, dv, ok, ck);
    end

    // Reset in the middle of WAIT: outputs clear at once, no late ack
    @(negedge clock);
    ctrl_num1    = 32'hDEAD_BEEF;
    ctrl_req_tog = ~ctrl_req_tog;
    @(negedge clock);
    unit_in_ready = 1'b1;
    @(negedge clock);
    unit_in_ready = 1'b0;
    @(negedge clock);
    check("rst_mid_busy", 64'(status_busy), 64'd1);
    #2;
    reset_n      = 1'b0;
    ctrl_req_tog = 1'b0;
    ctrl_clr_tog = 1'b0;
    #1;
    exp_ack = 1'b0; exp_cnt = 16'd0; exp_res = '0; exp_to = 1'b0; exp_ovr = 1'b0;
    check_status("rst_async");
    check("rst_async_num1", 64'(unit_num1), 64'd0);
    @(negedge clock);
    reset_n        = 1'b1;
    unit_out_valid = 1'b1;
    unit_result    = 32'h1111_2222;
    repeat (4) @(negedge clock);
    unit_out_valid = 1'b0;
    check_status("rst_after");

    run_op("post_rst", 2'd1, 32'h4000_0000, 32'h3000_0000, 32'h3800_0000, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
